instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Instruction fetch/sequencing stage that sits directly upstream of the executer. It fetches opcode and immediate bytes from program memory through a ready handshake and decodes a small fixed instruction set. It then emits, one clock per micro-step, the control word the executer consumes: ALU op, buffer latch select, bus source, output mux, carry source, write-back and flag latch. It owns the program counter and a halt state.

## Interface
- RESET_PC, 16'h0000, program counter value loaded by reset.
- clk  input  1  sole clock; all state changes on rising edge.
- nReset  input  1  synchronous, active-low reset, sampled on clk rising edge.
- memReady  input  1  program memory has valid memData for the current memRd request.
- memData  input  8  program memory read data.
- pc  output  16  fetch address, valid while memRd=1.
- memRd  output  1  program memory read request.
- dataIn  output  8  latched immediate byte, to executer dataIn.
- ALUOpecode  output  4  ALU function select.
- ALU_M  output  1  ALU mode, 0 arithmetic, 1 logic.
- cySelector  output  2  carry-in source: 00 flag carry, 10 constant 1.
- buffSel  output  2  01 latch operand buffer A, 10 latch operand buffer B, 00 none.
- byteRegSelector  output  3  internal bus source: 010 dataIn, 1rr byte register rr.
- wordRegSelector  output  2  held 00.
- misc  output  2  dataOut mux: 00 internal bus, 01 ALU arithmetic, 10 logic result.
- writeBackEnable  output  1  write dataOut to the register named by writeBackSel.
- writeBackSel  output  3  destination byte register.
- flagLatchEn  output  1  latch flags from ALU.
- stfr  output  1  held 0.
- halted  output  1  sequencer in HALT.

## Operation
- Opcode classes, by op[7:6]:
  - 00 ALU: ALUOpecode=op[3:0], ALU_M=op[4], cySelector=op[5]?10:00, A=reg0, B=reg1, result to reg0.
  - 01 LDI: the next byte is an immediate, written to reg op[2:0].
  - 10 MOV: reg op[4:3] is copied to reg op[2:0].
  - 11 other: NOP.
  - 8'hFF: HALT.
- States: FETCH, OPER, ALU1, ALU2, ALU3, LDX, MOVX, HALT.
- FETCH: memRd=1 until memReady. On the memReady cycle, latch op from memData and pc<=pc+1, then go to:
  - ALU1 for class 00;
  - OPER for class 01;
  - MOVX for class 10;
  - HALT for FF;
  - FETCH for other class-11 opcodes (NOP).
- OPER: memRd=1 until memReady. Latch dataIn<=memData, pc<=pc+1, then go to LDX.
- ALU1: byteRegSelector=100, buffSel=01.
- ALU2: byteRegSelector=101, buffSel=10.
- ALU3: misc=ALU_M?10:01, writeBackEnable=1, writeBackSel=000, flagLatchEn=1, then FETCH.
- LDX: byteRegSelector=010, misc=00, writeBackEnable=1, writeBackSel=op[2:0], then FETCH.
- MOVX: byteRegSelector={1,op[4:3]}, misc=00, writeBackEnable=1, writeBackSel=op[2:0], then FETCH.
- HALT: all control idle, halted=1, memRd=0. Only reset exits HALT.
- Idle control word is used in every state/cycle not listed above:
  - buffSel=00, byteRegSelector=000, misc=00, cySelector=00;
  - writeBackEnable=0, flagLatchEn=0, stfr=0, wordRegSelector=00.
- ALUOpecode, ALU_M and cySelector come from the latched op and hold through ALU1–ALU3.
- pc is 16-bit and wraps FFFF->0000 with no flag.

## Timing
- Reset values:
  - state=FETCH, pc=RESET_PC, op=00, dataIn=00;
  - all control outputs idle, memRd=0, halted=0.
- memRd rises the first cycle after nReset is sampled high.
- The control word is registered: each micro-step's outputs are stable for exactly one clk.
- memRd stays high until memReady is seen. memReady while memRd=0 is ignored.
- Zero-wait memory (memReady=1 always) gives these per-instruction cycle counts:
  - ALU 4 cycles;
  - LDI 3 cycles;
  - MOV 2 cycles;
  - NOP 1 cycle;
  - HALT 1 cycle to enter.
- Each wait cycle adds one cycle; pc holds during the wait.
- If reset is asserted mid-instruction or mid-wait, the next cycle is reset state and no partial write-back is issued.
- writeBackEnable and flagLatchEn are never high in the same cycle as memRd.

## Test plan
- Reset with RESET_PC=16'h1234, nReset low 2 cycles -> pc=1234, memRd=0, all controls idle. memRd=1 on the first cycle after release.
- memData=8'h05, memReady=1 -> next 3 cycles:
  - buffSel 01 with byteRegSelector 100;
  - buffSel 10 with byteRegSelector 101;
  - misc 01, ALUOpecode 0101, writeBackEnable 1, writeBackSel 000, flagLatchEn 1;
  - then FETCH at pc+1.
- Bytes 8'h43, 8'hA5 with memReady held low 2 cycles on the operand -> pc advances by 2 total. LDX cycle shows dataIn=A5, byteRegSelector 010, writeBackSel 011.
- 8'h9A (MOV reg3->reg2) -> one cycle with byteRegSelector 111, writeBackSel 010, writeBackEnable 1.
- pc=FFFF fetch of NOP 8'hC0 -> pc=0000. FF -> halted=1 and memRd stays 0 for 10 cycles.
- nReset low during ALU2 -> no ALU3 write-back. State returns to FETCH with pc=RESET_PC.

Source files
------------

// File: rtl/instr_sequencer.sv
// Instruction fetch/sequencing stage: fetches opcodes and immediates, decodes them,
// and issues one registered executer control word per micro-step.
module instr_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        memReady,
  input  logic [7:0]  memData,
  output logic [15:0] pc,
  output logic        memRd,
  output logic [7:0]  dataIn,
  output logic [3:0]  ALUOpecode,
  output logic        ALU_M,
  output logic [1:0]  cySelector,
  output logic [1:0]  buffSel,
  output logic [2:0]  byteRegSelector,
  output logic [1:0]  wordRegSelector,
  output logic [1:0]  misc,
  output logic        writeBackEnable,
  output logic [2:0]  writeBackSel,
  output logic        flagLatchEn,
  output logic        stfr,
  output logic        halted
);

  typedef enum logic [2:0] {
    FETCH, OPER, ALU1, ALU2, ALU3, LDX, MOVX, HALT
  } state_t;

  state_t      r_state, w_nextState;
  logic [15:0] r_pc, w_nextPc;
  // Only op[5:0] is needed after decode; the class bits steer the state choice.
  logic [5:0]  r_op, w_nextOp;
  logic [7:0]  r_dataIn, w_nextDataIn;
  logic        w_accept;

  logic        r_memRd, w_memRd;
  logic [1:0]  r_buffSel, w_buffSel;
  logic [2:0]  r_byteRegSel, w_byteRegSel;
  logic [1:0]  r_misc, w_misc;
  logic [1:0]  r_cySel, w_cySel;
  logic        r_wbEn, w_wbEn;
  logic [2:0]  r_wbSel, w_wbSel;
  logic        r_flagEn, w_flagEn;
  logic        r_halted, w_halted;

  assign w_accept = r_memRd && memReady;

  always_ff @(posedge clk) begin
    if (!nReset) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_op         <= '0;
      r_dataIn     <= '0;
      r_memRd      <= 1'b0;
      r_buffSel    <= '0;
      r_byteRegSel <= '0;
      r_misc       <= '0;
      r_cySel      <= '0;
      r_wbEn       <= 1'b0;
      r_wbSel      <= '0;
      r_flagEn     <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_state      <= w_nextState;
      r_pc         <= w_nextPc;
      r_op         <= w_nextOp;
      r_dataIn     <= w_nextDataIn;
      r_memRd      <= w_memRd;
      r_buffSel    <= w_buffSel;
      r_byteRegSel <= w_byteRegSel;
      r_misc       <= w_misc;
      r_cySel      <= w_cySel;
      r_wbEn       <= w_wbEn;
      r_wbSel      <= w_wbSel;
      r_flagEn     <= w_flagEn;
      r_halted     <= w_halted;
    end
  end

  // The control word is computed for the state being entered so it is registered alongside it.
  always_comb begin
    w_nextState  = r_state;
    w_nextPc     = r_pc;
    w_nextOp     = r_op;
    w_nextDataIn = r_dataIn;
    w_memRd      = 1'b0;
    w_buffSel    = 2'b00;
    w_byteRegSel = 3'b000;
    w_misc       = 2'b00;
    w_cySel      = 2'b00;
    w_wbEn       = 1'b0;
    w_wbSel      = 3'b000;
    w_flagEn     = 1'b0;
    w_halted     = 1'b0;

    case (r_state)
      FETCH: begin
        if (w_accept) begin
          w_nextOp = memData[5:0];
          w_nextPc = r_pc + 16'h0001;
          case (memData[7:6])
            2'b00:   w_nextState = ALU1;
            2'b01:   w_nextState = OPER;
            2'b10:   w_nextState = MOVX;
            default: w_nextState = (memData == 8'hFF) ? HALT : FETCH;
          endcase
        end
      end
      OPER: begin
        if (w_accept) begin
          w_nextDataIn = memData;
          w_nextPc     = r_pc + 16'h0001;
          w_nextState  = LDX;
        end
      end
      ALU1:    w_nextState = ALU2;
      ALU2:    w_nextState = ALU3;
      ALU3:    w_nextState = FETCH;
      LDX:     w_nextState = FETCH;
      MOVX:    w_nextState = FETCH;
      HALT:    w_nextState = HALT;
      default: w_nextState = FETCH;
    endcase

    case (w_nextState)
      FETCH, OPER: w_memRd = 1'b1;
      ALU1: begin
        w_byteRegSel = 3'b100;
        w_buffSel    = 2'b01;
        w_cySel      = w_nextOp[5] ? 2'b10 : 2'b00;
      end
      ALU2: begin
        w_byteRegSel = 3'b101;
        w_buffSel    = 2'b10;
        w_cySel      = w_nextOp[5] ? 2'b10 : 2'b00;
      end
      ALU3: begin
        w_misc   = w_nextOp[4] ? 2'b10 : 2'b01;
        w_wbEn   = 1'b1;
        w_wbSel  = 3'b000;
        w_flagEn = 1'b1;
        w_cySel  = w_nextOp[5] ? 2'b10 : 2'b00;
      end
      LDX: begin
        w_byteRegSel = 3'b010;
        w_wbEn       = 1'b1;
        w_wbSel      = w_nextOp[2:0];
      end
      MOVX: begin
        w_byteRegSel = {1'b1, w_nextOp[4:3]};
        w_wbEn       = 1'b1;
        w_wbSel      = w_nextOp[2:0];
      end
      HALT:    w_halted = 1'b1;
      default: w_memRd = 1'b0;
    endcase
  end

  assign pc              = r_pc;
  assign memRd           = r_memRd;
  assign dataIn          = r_dataIn;
  assign ALUOpecode      = r_op[3:0];
  assign ALU_M           = r_op[4];
  assign cySelector      = r_cySel;
  assign buffSel         = r_buffSel;
  assign byteRegSelector = r_byteRegSel;
  assign wordRegSelector = 2'b00;
  assign misc            = r_misc;
  assign writeBackEnable = r_wbEn;
  assign writeBackSel    = r_wbSel;
  assign flagLatchEn     = r_flagEn;
  assign stfr            = 1'b0;
  assign halted          = r_halted;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: reset, ALU/LDI/MOV sequencing, memory waits,
// pc wrap, HALT and reset in the middle of an instruction.
module tb_instr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nReset, memReady;
  logic [7:0]  memData;
  logic [15:0] pc;
  logic        memRd;
  logic [7:0]  dataIn;
  logic [3:0]  ALUOpecode;
  logic        ALU_M;
  logic [1:0]  cySelector, buffSel, wordRegSelector, misc;
  logic [2:0]  byteRegSelector, writeBackSel;
  logic        writeBackEnable, flagLatchEn, stfr, halted;

  logic        nReset2, memReady2;
  logic [7:0]  memData2;
  logic [15:0] pc2;
  logic        memRd2;
  logic [7:0]  dataIn2;
  logic [3:0]  ALUOpecode2;
  logic        ALU_M2;
  logic [1:0]  cySelector2, buffSel2, wordRegSelector2, misc2;
  logic [2:0]  byteRegSelector2, writeBackSel2;
  logic        writeBackEnable2, flagLatchEn2, stfr2, halted2;

  int errors = 0;
  int checks = 0;

  // {buffSel, byteRegSelector, misc, cySelector, wbEn, wbSel, flagLatchEn, stfr, wordRegSelector, halted}
  logic [17:0] ctrl;
  assign ctrl = {buffSel, byteRegSelector, misc, cySelector, writeBackEnable, writeBackSel,
                 flagLatchEn, stfr, wordRegSelector, halted};

  instr_sequencer #(.RESET_PC(16'h1234)) dut (
    .clk(clk), .nReset(nReset), .memReady(memReady), .memData(memData),
    .pc(pc), .memRd(memRd), .dataIn(dataIn), .ALUOpecode(ALUOpecode), .ALU_M(ALU_M),
    .cySelector(cySelector), .buffSel(buffSel), .byteRegSelector(byteRegSelector),
    .wordRegSelector(wordRegSelector), .misc(misc), .writeBackEnable(writeBackEnable),
    .writeBackSel(writeBackSel), .flagLatchEn(flagLatchEn), .stfr(stfr), .halted(halted)
  );

  instr_sequencer #(.RESET_PC(16'hFFFF)) dut2 (
    .clk(clk), .nReset(nReset2), .memReady(memReady2), .memData(memData2),
    .pc(pc2), .memRd(memRd2), .dataIn(dataIn2), .ALUOpecode(ALUOpecode2), .ALU_M(ALU_M2),
    .cySelector(cySelector2), .buffSel(buffSel2), .byteRegSelector(byteRegSelector2),
    .wordRegSelector(wordRegSelector2), .misc(misc2), .writeBackEnable(writeBackEnable2),
    .writeBackSel(writeBackSel2), .flagLatchEn(flagLatchEn2), .stfr(stfr2), .halted(halted2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    nReset = 1'b0; memReady = 1'b0; memData = 8'h00;
    tick(); tick();
    checks++; if (pc !== 16'h1234) begin errors++; $display("[TB] FAIL reset_pc got=%h exp=1234", pc); end
    checks++; if (memRd !== 1'b0) begin errors++; $display("[TB] FAIL reset_memRd got=%b exp=0", memRd); end
    checks++; if (ctrl !== 18'h0) begin errors++; $display("[TB] FAIL reset_ctrl got=%h exp=0", ctrl); end
    checks++; if ({dataIn, ALUOpecode, ALU_M} !== 13'h0) begin errors++; $display("[TB] FAIL reset_regs got=%h/%h/%b exp=0", dataIn, ALUOpecode, ALU_M); end
    // memReady while memRd is still low must not start a fetch
    nReset = 1'b1; memReady = 1'b1; memData = 8'h05;
    tick();
    checks++; if (memRd !== 1'b1) begin errors++; $display("[TB] FAIL release_memRd got=%b exp=1", memRd); end
    checks++; if (pc !== 16'h1234) begin errors++; $display("[TB] FAIL release_pc got=%h exp=1234", pc); end
    checks++; if (ctrl !== 18'h0) begin errors++; $display("[TB] FAIL release_ctrl got=%h exp=0", ctrl); end
  endtask

  task automatic test_alu();
    tick();
    checks++; if (ctrl !== {2'b01, 3'b100, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0}) begin errors++; $display("[TB] FAIL alu1_ctrl got=%h", ctrl); end
    checks++; if ({memRd, pc} !== {1'b0, 16'h1235}) begin errors++; $display("[TB] FAIL alu1_pc got=%b/%h exp=0/1235", memRd, pc); end
    memReady = 1'b0;
    tick();
    checks++; if (ctrl !== {2'b10, 3'b101, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0, 2'b00, 1'b0}) begin errors++; $display("[TB] FAIL alu2_ctrl got=%h", ctrl); end
    tick();
    checks++; if (ctrl !== {2'b00, 3'b000, 2'b01, 2'b00, 1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0}) begin errors++; $display("[TB] FAIL alu3_ctrl got=%h", ctrl); end
    checks++; if ({ALUOpecode, ALU_M, memRd} !== {4'b0101, 1'b0, 1'b0}) begin errors++; $display("[TB] FAIL alu3_op got=%b/%b/%b exp=0101/0/0", ALUOpecode, ALU_M, memRd); end
    tick();
    checks++; if ({memRd, pc, ctrl} !== {1'b1, 16'h1235, 18'h0}) begin errors++; $display("[TB] FAIL alu_fetch got=%b/%h/%h exp=1/1235/0", memRd, pc, ctrl); end
  endtask

  task automatic test_ldi_wait();
    memData = 8'h43; memReady = 1'b1;
    tick();
    checks++; if ({memRd, pc, ctrl} !== {1'b1, 16'h1236, 18'h0}) begin errors++; $display("[TB] FAIL ldi_oper got=%b/%h/%h exp=1/1236/0", memRd, pc, ctrl); end
    memData = 8'hA5; memReady = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({memRd, pc, ctrl} !== {1'b1, 16'h1236, 18'h0}) begin errors++; $display("[TB] FAIL ldi_wait%0d got=%b/%h/%h exp=1/1236/0", i, memRd, pc, ctrl); end
    end
    memReady = 1'b1;
    tick();
    checks++; if (dataIn !== 8'hA5) begin errors++; $display("[TB] FAIL ldx_dataIn got=%h exp=a5", dataIn); end
    checks++; if (ctrl !== {2'b00, 3'b010, 2'b00, 2'b00, 1'b1, 3'b011, 1'b0, 1'b0, 2'b00, 1'b0}) begin errors++; $display("[TB] FAIL ldx_ctrl got=%h", ctrl); end
    checks++; if ({memRd, pc} !== {1'b0, 16'h1237}) begin errors++; $display("[TB] FAIL ldx_pc got=%b/%h exp=0/1237", memRd, pc); end
    memReady = 1'b0;
    tick();
    checks++; if ({memRd, pc, ctrl} !== {1'b1, 16'h1237, 18'h0}) begin errors++; $display("[TB] FAIL ldi_fetch got=%b/%h/%h exp=1/1237/0", memRd, pc, ctrl); end
  endtask

  task automatic test_mov();
    memData = 8'h9A; memReady = 1'b1;
    tick();
    checks++; if (ctrl !== {2'b00, 3'b111, 2'b00, 2'b00, 1'b1, 3'b010, 1'b0, 1'b0, 2'b00, 1'b0}) begin errors++; $display("[TB] FAIL movx_ctrl got=%h", ctrl); end
    checks++; if ({memRd, pc} !== {1'b0, 16'h1238}) begin errors++; $display("[TB] FAIL movx_pc got=%b/%h exp=0/1238", memRd, pc); end
    memReady = 1'b0;
    tick();
    checks++; if ({memRd, ctrl} !== {1'b1, 18'h0}) begin errors++; $display("[TB] FAIL mov_fetch got=%b/%h exp=1/0", memRd, ctrl); end
  endtask

  task automatic test_alu_logic();
    memData = 8'h3F; memReady = 1'b1;
    tick();
    checks++; if ({cySelector, ALU_M, ALUOpecode} !== {2'b10, 1'b1, 4'hF}) begin errors++; $display("[TB] FAIL logic_alu1 got=%b/%b/%h exp=10/1/f", cySelector, ALU_M, ALUOpecode); end
    memReady = 1'b0;
    tick(); tick();
    checks++; if (ctrl !== {2'b00, 3'b000, 2'b10, 2'b10, 1'b1, 3'b000, 1'b1, 1'b0, 2'b00, 1'b0}) begin errors++; $display("[TB] FAIL logic_alu3 got=%h", ctrl); end
    tick();
    checks++; if ({memRd, pc, ctrl} !== {1'b1, 16'h1239, 18'h0}) begin errors++; $display("[TB] FAIL logic_fetch got=%b/%h/%h exp=1/1239/0", memRd, pc, ctrl); end
  endtask

  task automatic test_reset_mid();
    memData = 8'h05; memReady = 1'b1;
    tick();
    memReady = 1'b0;
    tick();
    checks++; if (buffSel !== 2'b10) begin errors++; $display("[TB] FAIL mid_alu2 got=%b exp=10", buffSel); end
    nReset = 1'b0;
    tick();
    checks++; if ({memRd, pc, ctrl} !== {1'b0, 16'h1234, 18'h0}) begin errors++; $display("[TB] FAIL mid_reset got=%b/%h/%h exp=0/1234/0", memRd, pc, ctrl); end
    tick();
    checks++; if ({writeBackEnable, flagLatchEn} !== 2'b00) begin errors++; $display("[TB] FAIL mid_nowb got=%b%b exp=00", writeBackEnable, flagLatchEn); end
    nReset = 1'b1;
    tick();
    checks++; if ({memRd, pc} !== {1'b1, 16'h1234}) begin errors++; $display("[TB] FAIL mid_release got=%b/%h exp=1/1234", memRd, pc); end
  endtask

  task automatic test_wrap_halt();
    nReset2 = 1'b1; memReady2 = 1'b1; memData2 = 8'hC0;
    tick();
    checks++; if ({memRd2, pc2} !== {1'b1, 16'hFFFF}) begin errors++; $display("[TB] FAIL wrap_start got=%b/%h exp=1/ffff", memRd2, pc2); end
    tick();
    checks++; if ({memRd2, pc2, halted2} !== {1'b1, 16'h0000, 1'b0}) begin errors++; $display("[TB] FAIL wrap_nop got=%b/%h/%b exp=1/0000/0", memRd2, pc2, halted2); end
    memData2 = 8'hFF;
    tick();
    checks++; if ({halted2, memRd2, pc2} !== {1'b1, 1'b0, 16'h0001}) begin errors++; $display("[TB] FAIL halt_enter got=%b/%b/%h exp=1/0/0001", halted2, memRd2, pc2); end
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++; if ({halted2, memRd2, writeBackEnable2} !== 3'b100) begin errors++; $display("[TB] FAIL halt_hold%0d got=%b/%b/%b exp=1/0/0", i, halted2, memRd2, writeBackEnable2); end
    end
  endtask

  initial begin
    nReset = 1'b0; memReady = 1'b0; memData = 8'h00;
    nReset2 = 1'b0; memReady2 = 1'b0; memData2 = 8'h00;
    test_reset();
    test_alu();
    test_ldi_wait();
    test_mov();
    test_alu_logic();
    test_reset_mid();
    test_wrap_halt();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
